// File: rtl/pipeline_w_writeback.sv
// M/W pipeline register and write-back datapath: registers M-stage results and forms the
// GRF write enable, address and data driven back into decode for the write port and forwarding.
module pipeline_w_writeback #(
   parameter logic [31:0] RESET_PCPLUS4 = 32'h00003004
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Clr_W,
   input  logic        RegWrite_M,
   input  logic [4:0]  RD_M,
   input  logic [1:0]  WDSel_M,
   input  logic [2:0]  LoadExt_M,
   input  logic [31:0] ALUOutput_M,
   input  logic [31:0] DMOut_M,
   input  logic [31:0] MDOut_M,
   input  logic [31:0] PCPlus4_M,
   output logic        RegWrite_W,
   output logic [4:0]  RD_W,
   output logic [31:0] MUXRFWDOut,
   output logic [31:0] PCPlus4_W
);

   localparam logic [1:0] WdAlu  = 2'b00;
   localparam logic [1:0] WdLoad = 2'b01;
   localparam logic [1:0] WdLink = 2'b10;
   localparam logic [1:0] WdHiLo = 2'b11;

   localparam logic [2:0] LdWord  = 3'b000;
   localparam logic [2:0] LdByteU = 3'b001;
   localparam logic [2:0] LdByteS = 3'b010;
   localparam logic [2:0] LdHalfU = 3'b011;
   localparam logic [2:0] LdHalfS = 3'b100;

   logic        r_reg_write;
   logic [4:0]  r_rd;
   logic [1:0]  r_wd_sel;
   logic [2:0]  r_load_ext;
   logic [31:0] r_alu_out;
   logic [31:0] r_dm_out;
   logic [31:0] r_md_out;
   logic [31:0] r_pc_plus4;

   logic [1:0]  w_byte_addr;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_link;
   logic [31:0] w_wd;

   // Writes to $0 are squashed here so neither the GRF nor forwarding ever sees them.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_reg_write <= 1'b0;
         r_rd        <= 5'd0;
         r_wd_sel    <= WdAlu;
         r_load_ext  <= LdWord;
         r_alu_out   <= 32'd0;
         r_dm_out    <= 32'd0;
         r_md_out    <= 32'd0;
         r_pc_plus4  <= RESET_PCPLUS4;
      end else if (Clr_W) begin
         r_reg_write <= 1'b0;
         r_rd        <= 5'd0;
         r_wd_sel    <= WdAlu;
         r_load_ext  <= LdWord;
         r_alu_out   <= 32'd0;
         r_dm_out    <= 32'd0;
         r_md_out    <= 32'd0;
         r_pc_plus4  <= PCPlus4_M;
      end else begin
         r_reg_write <= RegWrite_M & (RD_M != 5'd0);
         r_rd        <= RD_M;
         r_wd_sel    <= WDSel_M;
         r_load_ext  <= LoadExt_M;
         r_alu_out   <= ALUOutput_M;
         r_dm_out    <= DMOut_M;
         r_md_out    <= MDOut_M;
         r_pc_plus4  <= PCPlus4_M;
      end
   end

   always_comb begin
      w_byte_addr = r_alu_out[1:0];
      w_byte      = 8'd0;
      unique case (w_byte_addr)
         2'd0:    w_byte = r_dm_out[7:0];
         2'd1:    w_byte = r_dm_out[15:8];
         2'd2:    w_byte = r_dm_out[23:16];
         default: w_byte = r_dm_out[31:24];
      endcase
      w_half = w_byte_addr[1] ? r_dm_out[31:16] : r_dm_out[15:0];
   end

   // Unlisted load encodings fall back to a full-word load.
   always_comb begin
      w_load_data = r_dm_out;
      case (r_load_ext)
         LdByteU: w_load_data = {24'd0, w_byte};
         LdByteS: w_load_data = {{24{w_byte[7]}}, w_byte};
         LdHalfU: w_load_data = {16'd0, w_half};
         LdHalfS: w_load_data = {{16{w_half[15]}}, w_half};
         default: w_load_data = r_dm_out;
      endcase
   end

   assign w_link = r_pc_plus4 + 32'd4;

   always_comb begin
      w_wd = r_alu_out;
      unique case (r_wd_sel)
         WdAlu:   w_wd = r_alu_out;
         WdLoad:  w_wd = w_load_data;
         WdLink:  w_wd = w_link;
         WdHiLo:  w_wd = r_md_out;
         default: w_wd = r_alu_out;
      endcase
   end

   assign RegWrite_W = r_reg_write;
   assign RD_W       = r_rd;
   assign MUXRFWDOut = w_wd;
   assign PCPlus4_W  = r_pc_plus4;

endmodule

// File: tb/tb_pipeline_w_writeback.sv
// Scoreboard bench for pipeline_w_writeback: each driven M-stage slot pushes its expected
// W-stage result, which is popped and compared one edge later.
module tb_pipeline_w_writeback;

   localparam logic [31:0] ResetPc = 32'h00003004;

   typedef struct {
      string       tag;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [31:0] pc4;
   } exp_t;

   logic        CLK = 1'b0;
   logic        Reset, Clr_W, RegWrite_M;
   logic [4:0]  RD_M;
   logic [1:0]  WDSel_M;
   logic [2:0]  LoadExt_M;
   logic [31:0] ALUOutput_M, DMOut_M, MDOut_M, PCPlus4_M;
   logic        RegWrite_W;
   logic [4:0]  RD_W;
   logic [31:0] MUXRFWDOut, PCPlus4_W;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   pipeline_w_writeback #(.RESET_PCPLUS4(ResetPc)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .Clr_W       (Clr_W),
      .RegWrite_M  (RegWrite_M),
      .RD_M        (RD_M),
      .WDSel_M     (WDSel_M),
      .LoadExt_M   (LoadExt_M),
      .ALUOutput_M (ALUOutput_M),
      .DMOut_M     (DMOut_M),
      .MDOut_M     (MDOut_M),
      .PCPlus4_M   (PCPlus4_M),
      .RegWrite_W  (RegWrite_W),
      .RD_W        (RD_W),
      .MUXRFWDOut  (MUXRFWDOut),
      .PCPlus4_W   (PCPlus4_W)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference written with shifts/masks rather than lane muxes.
   function automatic logic [31:0] model_wd(input logic [1:0] sel, input logic [2:0] ext,
                                            input logic [31:0] alu, input logic [31:0] dm,
                                            input logic [31:0] md, input logic [31:0] pc4);
      logic [31:0] b, h, ld;
      b = (dm >> (alu[1:0] * 8)) & 32'hFF;
      h = (dm >> (alu[1] ? 16 : 0)) & 32'hFFFF;
      case (ext)
         3'd1:    ld = b;
         3'd2:    ld = b[7] ? (b | 32'hFFFFFF00) : b;
         3'd3:    ld = h;
         3'd4:    ld = h[15] ? (h | 32'hFFFF0000) : h;
         default: ld = dm;
      endcase
      case (sel)
         2'd0:    return alu;
         2'd1:    return ld;
         2'd2:    return pc4 + 32'd4;
         default: return md;
      endcase
   endfunction

   task automatic drive(input string tag, input logic rst, input logic clr, input logic rw,
                        input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] ext,
                        input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] md,
                        input logic [31:0] pc4);
      exp_t e, got;
      Reset = rst; Clr_W = clr; RegWrite_M = rw; RD_M = rd; WDSel_M = sel;
      LoadExt_M = ext; ALUOutput_M = alu; DMOut_M = dm; MDOut_M = md; PCPlus4_M = pc4;
      e.tag = tag;
      if (rst) begin
         e.we = 1'b0; e.rd = 5'd0; e.wd = 32'd0; e.pc4 = ResetPc;
      end else if (clr) begin
         e.we = 1'b0; e.rd = 5'd0; e.wd = 32'd0; e.pc4 = pc4;
      end else begin
         e.we = rw && (rd != 5'd0); e.rd = rd; e.pc4 = pc4;
         e.wd = model_wd(sel, ext, alu, dm, md, pc4);
      end
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      // Scramble inputs so outputs cannot depend combinationally on them.
      ALUOutput_M = $urandom; DMOut_M = $urandom; MDOut_M = $urandom; PCPlus4_M = $urandom;
      RD_M = 5'($urandom); RegWrite_M = 1'($urandom); WDSel_M = 2'($urandom);
      #1;
      got = sb_q.pop_front();
      check({got.tag, ".we"},  {31'd0, RegWrite_W}, {31'd0, got.we});
      check({got.tag, ".rd"},  {27'd0, RD_W},       {27'd0, got.rd});
      check({got.tag, ".wd"},  MUXRFWDOut,          got.wd);
      check({got.tag, ".pc4"}, PCPlus4_W,           got.pc4);
   endtask

   initial begin
      Reset = 1'b0; Clr_W = 1'b0; RegWrite_M = 1'b0; RD_M = '0; WDSel_M = '0; LoadExt_M = '0;
      ALUOutput_M = '0; DMOut_M = '0; MDOut_M = '0; PCPlus4_M = '0;
      @(posedge CLK);
      #1;
      // T1 reset with garbage inputs
      drive("reset", 1, 0, 1, 5'd17, 2'd3, 3'd2, 32'hDEADBEEF, 32'hCAFEF00D, 32'h13579BDF,
            32'hA5A5A5A5);
      // T2 ALU write
      drive("alu", 0, 0, 1, 5'd8, 2'd0, 3'd0, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h3008);
      // T3 loads
      drive("lb2",  0, 0, 1, 5'd9,  2'd1, 3'd2, 32'h10000002, 32'h80F17F01, 32'h0, 32'h300C);
      check("lb2.val", MUXRFWDOut, 32'hFFFFFFF1);
      drive("lbu3", 0, 0, 1, 5'd10, 2'd1, 3'd1, 32'h10000003, 32'h80F17F01, 32'h0, 32'h3010);
      check("lbu3.val", MUXRFWDOut, 32'h00000080);
      drive("lh2",  0, 0, 1, 5'd11, 2'd1, 3'd4, 32'h10000002, 32'h80F17F01, 32'h0, 32'h3014);
      check("lh2.val", MUXRFWDOut, 32'hFFFF80F1);
      drive("lhu0", 0, 0, 1, 5'd12, 2'd1, 3'd3, 32'h10000000, 32'h80F17F01, 32'h0, 32'h3018);
      check("lhu0.val", MUXRFWDOut, 32'h00007F01);
      drive("lhu1", 0, 0, 1, 5'd12, 2'd1, 3'd3, 32'h10000001, 32'h80F17F01, 32'h0, 32'h3018);
      drive("lw",   0, 0, 1, 5'd13, 2'd1, 3'd0, 32'h10000000, 32'h80F17F01, 32'h0, 32'h301C);
      drive("ldx7", 0, 0, 1, 5'd13, 2'd1, 3'd7, 32'h10000003, 32'h80F17F01, 32'h0, 32'h301C);
      drive("lb1",  0, 0, 1, 5'd14, 2'd1, 3'd2, 32'h10000001, 32'h80F17F01, 32'h0, 32'h3020);
      // T4 jal link and wrap
      drive("jal", 0, 0, 1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0, 32'h00003010);
      check("jal.val", MUXRFWDOut, 32'h00003014);
      drive("jalwrap", 0, 0, 1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC);
      check("jalwrap.val", MUXRFWDOut, 32'h00000000);
      drive("hilo", 0, 0, 1, 5'd2, 2'd3, 3'd0, 32'h1, 32'h2, 32'h87654321, 32'h3024);
      // T5 $0 gating
      drive("zero", 0, 0, 1, 5'd0, 2'd0, 3'd0, 32'd5, 32'h0, 32'h0, 32'h3028);
      check("zero.we", {31'd0, RegWrite_W}, 32'd0);
      drive("nowr", 0, 0, 0, 5'd7, 2'd0, 3'd0, 32'h0BADF00D, 32'h0, 32'h0, 32'h302C);
      // T6 Clr_W, Reset+Clr_W, reset mid-stream
      drive("clr", 0, 1, 1, 5'd9, 2'd3, 3'd2, 32'h55, 32'h66, 32'h77, 32'h00003020);
      check("clr.pc4", PCPlus4_W, 32'h00003020);
      drive("preRst", 0, 0, 1, 5'd4, 2'd0, 3'd0, 32'hAAAA5555, 32'h0, 32'h0, 32'h3030);
      drive("rstclr", 1, 1, 1, 5'd9, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0, 32'h00004000);
      check("rstclr.pc4", PCPlus4_W, 32'h00003004);
      drive("rstmid", 1, 0, 1, 5'd6, 2'd0, 3'd0, 32'h11111111, 32'h0, 32'h0, 32'h3034);
      // Back-to-back random stream: every slot is checked on its own cycle
      for (int i = 0; i < 60; i++) begin
         drive($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
               1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom_range(0, 5)),
               $urandom, $urandom, $urandom, $urandom);
      end
      check("sb.empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
